// File: rtl/siso_shift_ctrl.sv
// ---------------------------------------------------------------------------
// siso_shift_ctrl
//
// Sequencer that feeds a downstream N-deep serial-in/serial-out shift
// register. Parallel words arrive over a valid/ready handshake. Each word is
// serialized MSB-first onto shift_data, and shift_en strobes once per bit.
// Bits are paced by a programmable divider: one bit every div+1 clocks.
// A word tagged "last" is followed by DEPTH zero bits, which drain the final
// data out of the downstream register.
//
// Optional feature, compile-time macro SISO_CTRL_PARITY_EN:
//   When defined, an extra even-parity bit (XOR of the word) follows the WIDTH
//   data bits in state S_PAR, so each word costs WIDTH+1 strobes.
//   When undefined, the parity state and logic are absent.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset (0 = in reset)
//   div         bit period minus one, in clk cycles; sampled at word accept
//   in_valid    input word valid
//   in_ready    controller can accept a word (registered, low during reset)
//   in_data     parallel word, MSB shifted first
//   in_last     word closes a frame; a DEPTH-bit zero flush follows it
//   shift_en    one-cycle shift strobe to the downstream register
//   shift_data  serial bit for the downstream register, valid with shift_en
//   busy        high in every state except IDLE
//   done        one-cycle pulse, one cycle after a word's final strobe
//   frame_cnt   number of completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module siso_shift_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] div,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             shift_en,
   output logic             shift_data,
   output logic             busy,
   output logic             done,
   output logic [7:0]       frame_cnt
);

   // The bit counter is shared by the data phase and the flush phase, so it
   // has to be wide enough for whichever of the two is longer.
   localparam int MAX_BITS = (WIDTH > DEPTH) ? WIDTH : DEPTH;
   localparam int BIT_W    = $clog2(MAX_BITS + 1);

   localparam logic [BIT_W-1:0] LAST_DATA_BIT  = BIT_W'(WIDTH - 1);
   localparam logic [BIT_W-1:0] LAST_FLUSH_BIT = BIT_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
`ifdef SISO_CTRL_PARITY_EN
      S_PAR   = 3'd2,
`endif
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q,      state_d;
   logic [DIV_W-1:0] div_q,        div_d;
   logic [DIV_W-1:0] cnt_q,        cnt_d;
   logic [BIT_W-1:0] bit_cnt_q,    bit_cnt_d;
   logic [WIDTH-1:0] hold_q,       hold_d;
   logic             last_q,       last_d;
   logic             in_ready_q,   in_ready_d;
   logic             shift_en_q,   shift_en_d;
   logic             shift_data_q, shift_data_d;
   logic             done_q,       done_d;
   logic [7:0]       frame_cnt_q,  frame_cnt_d;
`ifdef SISO_CTRL_PARITY_EN
   logic             parity_q,     parity_d;
`endif

   logic             pacing;
   logic             tick;

   // Next-state and datapath logic. The divider only runs in the bit-emitting
   // states; a tick fires when the counter reaches the latched divisor and
   // the counter reloads to zero, so every state entry starts a fresh period.
   // Strobe and serial bit are registered so shift_en is a clean one-cycle
   // pulse aligned with its data bit.
   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      cnt_d        = cnt_q;
      bit_cnt_d    = bit_cnt_q;
      hold_d       = hold_q;
      last_d       = last_q;
      done_d       = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      shift_data_d = 1'b0;
`ifdef SISO_CTRL_PARITY_EN
      parity_d     = parity_q;
`endif

      pacing = (state_q == S_SHIFT) || (state_q == S_FLUSH)
`ifdef SISO_CTRL_PARITY_EN
               || (state_q == S_PAR)
`endif
               ;
      tick       = pacing && (cnt_q == div_q);
      shift_en_d = tick;

      if (pacing) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               hold_d    = in_data;
               last_d    = in_last;
               div_d     = div;
               cnt_d     = '0;
               bit_cnt_d = '0;
`ifdef SISO_CTRL_PARITY_EN
               parity_d  = ^in_data;
`endif
               state_d   = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (tick) begin
               shift_data_d = hold_q[WIDTH-1];
               hold_d       = {hold_q[WIDTH-2:0], 1'b0};
               if (bit_cnt_q == LAST_DATA_BIT) begin
                  bit_cnt_d = '0;
`ifdef SISO_CTRL_PARITY_EN
                  state_d   = S_PAR;
`else
                  state_d   = last_q ? S_FLUSH : S_DONE;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

`ifdef SISO_CTRL_PARITY_EN
         S_PAR: begin
            if (tick) begin
               shift_data_d = parity_q;
               state_d      = last_q ? S_FLUSH : S_DONE;
            end
         end
`endif

         S_FLUSH: begin
            // Zero bits push the final word through the downstream register.
            if (tick) begin
               shift_data_d = 1'b0;
               if (bit_cnt_q == LAST_FLUSH_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = S_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

         S_DONE: begin
            // done is registered here, so it appears one cycle after the
            // final strobe, coinciding with the return to IDLE.
            done_d = 1'b1;
            if (last_q) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // in_ready is registered from the next state: it stays low while reset
      // is held and rises one clock after release, and it drops on the same
      // edge that accepts a word, so only one word is ever in flight.
      in_ready_d = (state_d == S_IDLE);
   end

   // State and datapath registers. Reset aborts any word or flush at once:
   // strobes stop immediately and no done or frame count is produced.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         hold_q       <= '0;
         last_q       <= 1'b0;
         in_ready_q   <= 1'b0;
         shift_en_q   <= 1'b0;
         shift_data_q <= 1'b0;
         done_q       <= 1'b0;
         frame_cnt_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         hold_q       <= hold_d;
         last_q       <= last_d;
         in_ready_q   <= in_ready_d;
         shift_en_q   <= shift_en_d;
         shift_data_q <= shift_data_d;
         done_q       <= done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

`ifdef SISO_CTRL_PARITY_EN
   // Parity of the accepted word, emitted after its data bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   assign in_ready   = in_ready_q;
   assign shift_en   = shift_en_q;
   assign shift_data = shift_data_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// ---------------------------------------------------------------------------
// tb_siso_shift_ctrl
//
// Self-checking bench for siso_shift_ctrl. Monitors log every accept edge,
// strobe (time and bit) and done pulse into queues, indexed by clock edge.
// Expected behaviour comes from plain arithmetic on the word: the bit list is
// the word MSB-first (plus parity when SISO_CTRL_PARITY_EN is defined) and
// DEPTH zeros for a last word; strobe k lands at accept + (k+1)*(div+1) and
// done one cycle after the final strobe.
// ---------------------------------------------------------------------------
module tb_siso_shift_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int DIV_W = 8;
`ifdef SISO_CTRL_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [DIV_W-1:0] div = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             shift_en;
   logic             shift_data;
   logic             busy;
   logic             done;
   logic [7:0]       frame_cnt;

   int   cyc = 0;
   int   acceptQ[$];
   int   strobeT[$];
   logic strobeD[$];
   int   doneQ[$];

   int   checks = 0;
   int   errors = 0;
   int   expFrames = 0;

   siso_shift_ctrl #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .DIV_W(DIV_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .div       (div),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .shift_en  (shift_en),
      .shift_data(shift_data),
      .busy      (busy),
      .done      (done),
      .frame_cnt (frame_cnt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Edge counter and accept logger; the handshake is read before the DUT's
   // registers update on this edge, and the edge gets number cyc+1.
   always @(posedge clk) begin
      if (in_valid === 1'b1 && in_ready === 1'b1) acceptQ.push_back(cyc + 1);
      cyc <= cyc + 1;
   end

   // Output logger, sampled mid-cycle; cyc is the number of the last edge.
   always @(negedge clk) begin
      if (shift_en === 1'b1) begin
         strobeT.push_back(cyc);
         strobeD.push_back(shift_data);
      end
      if (done === 1'b1) doneQ.push_back(cyc);
   end

   // Moves to just after the next falling edge, after the loggers have run.
   task automatic waitCyc();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the next accept edge.
   task automatic waitAccept(output int acc);
      for (int i = 0; i < 3000 && acceptQ.size() == 0; i++) waitCyc();
      check("accepted", (acceptQ.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      acc = (acceptQ.size() != 0) ? acceptQ.pop_front() : -100000;
   endtask

   // Presents one word, waits for it to be taken, then scrambles the inputs
   // so any late sampling of them would show up as a wrong bit or period.
   task automatic applyStimulus(input logic [7:0] data, input logic last, input int divv,
                                output int acc);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      div      = DIV_W'(divv);
      waitAccept(acc);
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      in_last  = 1'(($urandom));
      div      = DIV_W'($urandom);
   endtask

   // Waits for the word's done, then compares every strobe, the done time
   // and the frame counter against the arithmetic model.
   task automatic checkOutput(input logic [7:0] data, input logic last, input int divv,
                              input int acc, output int doneAt);
      logic expBits[$];
      int   n;
      int   t;
      logic b;
      n = WIDTH + PAR_BITS + (last ? DEPTH : 0);
      for (int i = WIDTH - 1; i >= 0; i--) expBits.push_back(data[i]);
      if (PAR_BITS == 1) expBits.push_back(^data);
      if (last) for (int i = 0; i < DEPTH; i++) expBits.push_back(1'b0);

      for (int i = 0; i < (n + 2) * (divv + 1) + 10 && doneQ.size() == 0; i++) waitCyc();
      check("done_seen", (doneQ.size() != 0) ? 32'd1 : 32'd0, 32'd1);

      for (int k = 0; k < n; k++) begin
         if (strobeT.size() == 0) begin
            check("strobe_count", k, n);
            break;
         end
         t = strobeT.pop_front();
         b = strobeD.pop_front();
         check($sformatf("strobe%0d_time", k), t, acc + (k + 1) * (divv + 1));
         check($sformatf("strobe%0d_bit", k), {31'd0, b}, {31'd0, expBits[k]});
      end

      doneAt = (doneQ.size() != 0) ? doneQ.pop_front() : -100000;
      check("done_time", doneAt, acc + n * (divv + 1) + 1);

      expFrames = (expFrames + (last ? 1 : 0)) % 256;
      check("frame_cnt", {24'd0, frame_cnt}, expFrames);
   endtask

   // After a word: nothing more comes out and the controller sits idle.
   task automatic idleCheck();
      waitCyc();
      waitCyc();
      check("no_extra_done", doneQ.size(), 0);
      check("no_extra_strobe", strobeT.size(), 0);
      check("idle_busy", {31'd0, busy}, 0);
      check("idle_in_ready", {31'd0, in_ready}, 1);
   endtask

   task automatic runWord(input logic [7:0] data, input logic last, input int divv);
      int acc;
      int d;
      applyStimulus(data, last, divv, acc);
      checkOutput(data, last, divv, acc, d);
      idleCheck();
   endtask

   initial begin
      int acc1;
      int acc2;
      int d1;
      int d2;

      // Reset held for three cycles.
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         waitCyc();
         check("rst_in_ready", {31'd0, in_ready}, 0);
         check("rst_busy", {31'd0, busy}, 0);
         check("rst_shift_en", {31'd0, shift_en}, 0);
         check("rst_done", {31'd0, done}, 0);
         check("rst_frame_cnt", {24'd0, frame_cnt}, 0);
      end
      reset = 1'b1;
      waitCyc();
      check("post_rst_in_ready", {31'd0, in_ready}, 1);
      check("post_rst_busy", {31'd0, busy}, 0);
      check("post_rst_frame_cnt", {24'd0, frame_cnt}, 0);

      $display("[TB] directed words");
      runWord(8'hA5, 1'b0, 0);
      runWord(8'h81, 1'b1, 3);
      runWord(8'h07, 1'b0, 0);
      runWord(8'h03, 1'b0, 0);

      // Back-to-back words with in_valid held high; div and data change
      // while the first word is still shifting.
      $display("[TB] back-to-back words");
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_last  = 1'b0;
      div      = 8'd0;
      waitAccept(acc1);
      in_data  = 8'h00;
      div      = 8'd5;
      checkOutput(8'hFF, 1'b0, 0, acc1, d1);
      waitAccept(acc2);
      in_valid = 1'b0;
      check("b2b_accept_gap", acc2, d1 + 1);
      checkOutput(8'h00, 1'b0, 5, acc2, d2);
      idleCheck();

      $display("[TB] slowest bit period");
      runWord(8'h96, 1'b0, 255);

      $display("[TB] random words");
      for (int i = 0; i < 30; i++) begin
         runWord(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      $display("[TB] frame counter wrap");
      for (int i = 0; i < 258; i++) begin
         runWord(8'($urandom), 1'b1, 0);
      end

      // Reset in the middle of a framed word after three strobes.
      $display("[TB] reset mid-word");
      applyStimulus(8'h5A, 1'b1, 2, acc1);
      for (int i = 0; i < 100 && strobeT.size() < 3; i++) waitCyc();
      check("midrst_strobes_before", strobeT.size(), 3);
      reset = 1'b0;
      expFrames = 0;
      #1;
      check("midrst_shift_en", {31'd0, shift_en}, 0);
      check("midrst_busy", {31'd0, busy}, 0);
      check("midrst_in_ready", {31'd0, in_ready}, 0);
      waitCyc();
      waitCyc();
      reset = 1'b1;
      for (int i = 0; i < 60; i++) waitCyc();
      check("midrst_no_more_strobes", strobeT.size(), 3);
      check("midrst_no_done", doneQ.size(), 0);
      check("midrst_frame_cnt", {24'd0, frame_cnt}, expFrames);
      check("midrst_idle_busy", {31'd0, busy}, 0);
      check("midrst_idle_in_ready", {31'd0, in_ready}, 1);
      strobeT.delete();
      strobeD.delete();
      acceptQ.delete();

      // Normal operation resumes after the aborted word.
      runWord(8'hC3, 1'b1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
